// File: rtl/img_mem_op_arbiter.sv
// img_mem_op_arbiter
// Shares the single memory-interface port between four image-memory
// requesters: camera capture write, image readout, image erase and
// image-size query. One operation is granted at a time by fixed priority
// (cap > rd > er > sz). The winner's index is latched and a start pulse is
// issued. Completion is then tracked, a readout may be stopped by its
// requester, and a hung interface is aborted via a timeout. A single done
// pulse with status is returned to the owning requester.
//
// Ports:
//   sysClk, sysRst_n        clock, asynchronous active-low reset
//   *_req / *_idx           request level and image index per requester
//   rd_stop                 stop request for an in-flight readout
//   mem_done                completion pulse from the memory interface
//   mem_start / mem_abort   one-cycle command pulses to the memory interface
//   mem_op / mem_index      operation code and index, held for the operation
//   *_ack / *_done          grant and completion pulses per requester
//   done_status             0 normal, 1 aborted; valid with any *_done
//   op_timeout              pulses when the WAIT timeout fires
//   busy                    high whenever the arbiter is not idle
module img_mem_op_arbiter #(
   parameter int unsigned       TO_W           = 24,
   parameter logic [TO_W-1:0]   TIMEOUT_CYCLES = 24'hFFFFFF
) (
   input  logic        sysClk,
   input  logic        sysRst_n,
   input  logic        cap_req,
   input  logic        rd_req,
   input  logic        er_req,
   input  logic        sz_req,
   input  logic [11:0] cap_idx,
   input  logic [11:0] rd_idx,
   input  logic [11:0] er_idx,
   input  logic [11:0] sz_idx,
   input  logic        rd_stop,
   input  logic        mem_done,
   output logic        mem_start,
   output logic        mem_abort,
   output logic [1:0]  mem_op,
   output logic [11:0] mem_index,
   output logic        cap_ack,
   output logic        rd_ack,
   output logic        er_ack,
   output logic        sz_ack,
   output logic        cap_done,
   output logic        rd_done,
   output logic        er_done,
   output logic        sz_done,
   output logic        done_status,
   output logic        op_timeout,
   output logic        busy
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_WAIT   = 2'd1,
      ST_ABORT  = 2'd2,
      ST_FINISH = 2'd3
   } state_t;

   // Owner codes coincide with the mem_op encoding of each requester.
   localparam logic [1:0] OWN_CAP = 2'd0;
   localparam logic [1:0] OWN_RD  = 2'd1;
   localparam logic [1:0] OWN_ER  = 2'd2;
   localparam logic [1:0] OWN_SZ  = 2'd3;

   localparam logic [TO_W-1:0] TO_LAST = TIMEOUT_CYCLES - TO_W'(1);

   state_t            state_q, state_d;
   logic [TO_W-1:0]   timer_q, timer_d;
   logic [1:0]        owner_q, owner_d;
   logic              abort_flag_q, abort_flag_d;
   logic [1:0]        op_q, op_d;
   logic [11:0]       index_q, index_d;
   logic              start_q, start_d;
   logic              abort_q, abort_d;
   logic              timeout_q, timeout_d;
   logic              status_q, status_d;
   logic              busy_q, busy_d;
   logic [3:0]        ack_q, ack_d;
   logic [3:0]        done_q, done_d;

   logic              any_req;
   logic [1:0]        win;
   logic [11:0]       win_idx;

   assign any_req = cap_req | rd_req | er_req | sz_req;

   // Fixed-priority winner selection; only meaningful when any_req is high.
   always_comb begin
      win     = OWN_CAP;
      win_idx = cap_idx;
      if (cap_req) begin
         win     = OWN_CAP;
         win_idx = cap_idx;
      end else if (rd_req) begin
         win     = OWN_RD;
         win_idx = rd_idx;
      end else if (er_req) begin
         win     = OWN_ER;
         win_idx = er_idx;
      end else if (sz_req) begin
         win     = OWN_SZ;
         win_idx = sz_idx;
      end
   end

   // Next-state and registered-output computation. Pulses default low;
   // in WAIT, completion beats stop, and stop beats the timeout.
   always_comb begin
      state_d      = state_q;
      timer_d      = timer_q;
      owner_d      = owner_q;
      abort_flag_d = abort_flag_q;
      op_d         = op_q;
      index_d      = index_q;
      start_d      = 1'b0;
      abort_d      = 1'b0;
      timeout_d    = 1'b0;
      status_d     = 1'b0;
      ack_d        = 4'b0000;
      done_d       = 4'b0000;

      case (state_q)
         ST_IDLE: begin
            if (any_req) begin
               owner_d      = win;
               op_d         = win;
               index_d      = win_idx;
               start_d      = 1'b1;
               ack_d[win]   = 1'b1;
               timer_d      = '0;
               abort_flag_d = 1'b0;
               state_d      = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (mem_done) begin
               state_d = ST_FINISH;
            end else if (rd_stop && (owner_q == OWN_RD)) begin
               abort_d      = 1'b1;
               abort_flag_d = 1'b1;
               timer_d      = '0;
               state_d      = ST_ABORT;
            end else if (timer_q == TO_LAST) begin
               abort_d      = 1'b1;
               timeout_d    = 1'b1;
               abort_flag_d = 1'b1;
               timer_d      = '0;
               state_d      = ST_ABORT;
            end else begin
               timer_d = timer_q + TO_W'(1);
            end
         end
         ST_ABORT: begin
            // The interface gets one more timeout window to acknowledge;
            // after that the operation is retired without a second abort.
            if (mem_done || (timer_q == TO_LAST)) begin
               state_d = ST_FINISH;
            end else begin
               timer_d = timer_q + TO_W'(1);
            end
         end
         ST_FINISH: begin
            done_d[owner_q] = 1'b1;
            status_d        = abort_flag_q;
            op_d            = 2'b00;
            index_d         = 12'h000;
            state_d         = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   // State and output registers; reset drops everything to idle with no
   // abort sent to the interface.
   always_ff @(posedge sysClk or negedge sysRst_n) begin
      if (!sysRst_n) begin
         state_q      <= ST_IDLE;
         timer_q      <= '0;
         owner_q      <= 2'b00;
         abort_flag_q <= 1'b0;
         op_q         <= 2'b00;
         index_q      <= 12'h000;
         start_q      <= 1'b0;
         abort_q      <= 1'b0;
         timeout_q    <= 1'b0;
         status_q     <= 1'b0;
         busy_q       <= 1'b0;
         ack_q        <= 4'b0000;
         done_q       <= 4'b0000;
      end else begin
         state_q      <= state_d;
         timer_q      <= timer_d;
         owner_q      <= owner_d;
         abort_flag_q <= abort_flag_d;
         op_q         <= op_d;
         index_q      <= index_d;
         start_q      <= start_d;
         abort_q      <= abort_d;
         timeout_q    <= timeout_d;
         status_q     <= status_d;
         busy_q       <= busy_d;
         ack_q        <= ack_d;
         done_q       <= done_d;
      end
   end

   assign mem_start   = start_q;
   assign mem_abort   = abort_q;
   assign mem_op      = op_q;
   assign mem_index   = index_q;
   assign cap_ack     = ack_q[OWN_CAP];
   assign rd_ack      = ack_q[OWN_RD];
   assign er_ack      = ack_q[OWN_ER];
   assign sz_ack      = ack_q[OWN_SZ];
   assign cap_done    = done_q[OWN_CAP];
   assign rd_done     = done_q[OWN_RD];
   assign er_done     = done_q[OWN_ER];
   assign sz_done     = done_q[OWN_SZ];
   assign done_status = status_q;
   assign op_timeout  = timeout_q;
   assign busy        = busy_q;

endmodule
